// File: rtl/instr_fetch_pkg.sv
// Shared opcode, jump-condition and status-register definitions for the fetch stage.
package instr_fetch_pkg;

    // Top three opcode bits of a conditional/unconditional jump
    localparam logic [2:0] OP_JUMP = 3'b001;

    // Jump condition codes carried in ir_word[12:10]
    typedef enum logic [2:0] {
        JC_NE  = 3'b000,
        JC_EQ  = 3'b001,
        JC_NC  = 3'b010,
        JC_C   = 3'b011,
        JC_N   = 3'b100,
        JC_GE  = 3'b101,
        JC_L   = 3'b110,
        JC_JMP = 3'b111
    } jump_cond_e;

    // Bit positions inside sr_flags = {V,N,Z,C}
    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 3;

    // One fetch-queue entry: the word and the address it came from
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] word;
    } fetch_entry_t;

    // Evaluate a jump condition against the current status flags
    function automatic logic jump_taken(input jump_cond_e cond, input logic [3:0] flags);
        logic taken;
        taken = 1'b0;
        case (cond)
            JC_NE:  taken = !flags[SR_Z];
            JC_EQ:  taken =  flags[SR_Z];
            JC_NC:  taken = !flags[SR_C];
            JC_C:   taken =  flags[SR_C];
            JC_N:   taken =  flags[SR_N];
            JC_GE:  taken = !(flags[SR_N] ^ flags[SR_V]);
            JC_L:   taken =  (flags[SR_N] ^ flags[SR_V]);
            JC_JMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry FIFO of {addr,word} pairs between the ROM and the decoder.
// Clear dominates push and pop so a redirect always leaves the queue empty.
module fetch_queue
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    // Entry storage; written on push unless the same cycle clears the queue
    // NOTE: the storage array is deliberately not reset; count alone says which entries are live and head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, fills a 2-entry queue from ROM,
// hands words to the decoder and resolves jumps and explicit PC loads.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    output logic        rom_rd,
    input  logic [15:0] rom_data,
    output logic [15:0] ir_word,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        dec_opword,
    input  logic [3:0]  sr_flags,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic        flush
);

    localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

    logic [15:0]  fetch_pc;
    logic         q_full;
    logic         q_empty;
    logic         pop;
    logic         taken;
    logic         redirect;
    logic [15:0]  jump_offset;
    logic [15:0]  jump_target;
    fetch_entry_t q_head;
    fetch_entry_t q_push_data;

    assign pop      = ir_valid && ir_ready;
    assign rom_rd   = !rst && (!q_full || pop);
    assign rom_addr = fetch_pc;

    assign ir_valid = !q_empty;
    assign ir_word  = q_head.word;
    // With nothing queued, report the address about to be fetched (RESET_PC out of reset)
    assign ir_pc    = q_empty ? fetch_pc : q_head.addr;

    // Word offset of the jump, sign-extended and scaled to bytes
    assign jump_offset = {{5{ir_word[9]}}, ir_word[9:0], 1'b0};
    assign jump_target = ir_pc + 16'd2 + jump_offset;

    // Only opcode words popped by the decoder are ever treated as jumps
    assign taken = pop && dec_opword && (ir_word[15:13] == OP_JUMP)
                 && jump_taken(jump_cond_e'(ir_word[12:10]), sr_flags);

    assign redirect = pc_load || taken;

    assign q_push_data = '{addr: fetch_pc, word: rom_data};

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (rom_rd),
        .pop       (pop),
        .clear     (redirect),
        .push_data (q_push_data),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Fetch PC: explicit load beats a taken jump, which beats sequential advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC_ALIGNED;
            flush    <= 1'b0;
        end else begin
            flush <= redirect;
            if (pc_load) begin
                fetch_pc <= pc_load_val & 16'hFFFE;
            end else if (taken) begin
                fetch_pc <= jump_target;
            end else if (rom_rd) begin
                fetch_pc <= fetch_pc + 16'd2;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic,
// compared every cycle against a transaction-level queue model.
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [15:0] rom_data;
    logic [15:0] ir_word;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        dec_opword;
    logic [3:0]  sr_flags;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        flush;

    logic [15:0] rom [0:32767];
    assign rom_data = rom[rom_addr[15:1]];

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_rd      (rom_rd),
        .rom_data    (rom_data),
        .ir_word     (ir_word),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .dec_opword  (dec_opword),
        .sr_flags    (sr_flags),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    logic        m_flush;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Condition table, flags = {V,N,Z,C}
    function automatic logic cond_met(input logic [2:0] cc, input logic [3:0] f);
        logic v, n, z, c;
        v = f[3]; n = f[2]; z = f[1]; c = f[0];
        case (cc)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !c;
            3'd3:    return c;
            3'd4:    return n;
            3'd5:    return n == v;
            3'd6:    return n != v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] jump_dest(input logic [15:0] addr, input logic [15:0] word);
        int off;
        int dest;
        off = int'(word[9:0]);
        if (word[9]) off = off - 1024;
        dest = int'(addr) + 2 + 2 * off;
        return 16'(dest & 'hFFFF);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = RESET_PC & 16'hFFFE;
        m_flush = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare, advance model after posedge.
    task automatic step(input logic rdy, input logic opw, input logic [3:0] fl,
                        input logic pl, input logic [15:0] plv);
        logic        pop;
        logic        rd;
        logic        tk;
        logic [15:0] tgt;
        ent_t        fetched;
        @(negedge clk);
        ir_ready    = rdy;
        dec_opword  = opw;
        sr_flags    = fl;
        pc_load     = pl;
        pc_load_val = plv;
        #1;
        pop = (mq.size() > 0) && rdy;
        rd  = (mq.size() < 2) || pop;
        check("rom_addr", rom_addr, m_pc);
        check("rom_rd",   rom_rd, rd);
        check("ir_valid", ir_valid, mq.size() > 0);
        check("ir_word",  ir_word, (mq.size() > 0) ? mq[0].word : 16'h0000);
        if (mq.size() > 0) check("ir_pc", ir_pc, mq[0].addr);
        check("flush", flush, m_flush);
        tk  = 1'b0;
        tgt = 16'h0000;
        if (pop && opw && mq[0].word[15:13] == 3'b001 && cond_met(mq[0].word[12:10], fl)) begin
            tk  = 1'b1;
            tgt = jump_dest(mq[0].addr, mq[0].word);
        end
        fetched.addr = m_pc;
        fetched.word = rom[m_pc[15:1]];
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (pl) begin
            mq.delete();
            m_pc    = plv & 16'hFFFE;
            m_flush = 1'b1;
        end else if (tk) begin
            mq.delete();
            m_pc    = tgt;
            m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            if (rd) begin
                mq.push_back(fetched);
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h4034;
        rom[1] = 16'h1234;
        rom[2] = 16'h4303;
        rom[3] = 16'h3C00;

        rst         = 1'b1;
        ir_ready    = 1'b0;
        dec_opword  = 1'b0;
        sr_flags    = 4'h0;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        model_reset();
        #1;
        check("rst_valid",   ir_valid, 1'b0);
        check("rst_word",    ir_word, 16'h0000);
        check("rst_pc",      ir_pc, RESET_PC);
        check("rst_romaddr", rom_addr, RESET_PC);
        check("rst_romrd",   rom_rd, 1'b0);
        check("rst_flush",   flush, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Straight line after reset release
        step(1, 0, 4'h0, 0, 16'h0);
        check("sl_pc0", ir_pc, 16'h0000);  check("sl_w0", ir_word, 16'h4034);
        step(1, 1, 4'h0, 0, 16'h0);
        check("sl_pc2", ir_pc, 16'h0002);  check("sl_w2", ir_word, 16'h1234);
        step(1, 0, 4'h0, 0, 16'h0);
        check("sl_pc4", ir_pc, 16'h0004);  check("sl_w4", ir_word, 16'h4303);
        step(1, 1, 4'h0, 0, 16'h0);
        check("sl_pc6", ir_pc, 16'h0006);  check("sl_w6", ir_word, 16'h3C00);
        step(1, 1, 4'h0, 0, 16'h0);
        check("sl_jmp0_flush", flush, 1'b1);
        step(1, 0, 4'h0, 0, 16'h0);
        check("sl_pc8", ir_pc, 16'h0008);  check("sl_v8", ir_valid, 1'b1);

        // Taken jump: JMP +3 at 0x0010
        rom[16'h0010 >> 1] = 16'h3C03;
        step(1, 0, 4'h0, 1, 16'h0010);
        check("ld_flush", flush, 1'b1);    check("ld_valid", ir_valid, 1'b0);
        check("ld_addr", rom_addr, 16'h0010);
        step(1, 0, 4'h0, 0, 16'h0);
        check("tj_head", ir_word, 16'h3C03);
        step(1, 1, 4'h0, 0, 16'h0);
        check("tj_flush", flush, 1'b1);    check("tj_valid", ir_valid, 1'b0);
        check("tj_addr", rom_addr, 16'h0018);
        step(1, 0, 4'h0, 0, 16'h0);
        check("tj_pc", ir_pc, 16'h0018);   check("tj_v", ir_valid, 1'b1);

        // Not-taken JEQ with Z=0 falls through
        rom[16'h0010 >> 1] = 16'h2404;
        step(1, 0, 4'h0, 1, 16'h0010);
        step(1, 0, 4'h0, 0, 16'h0);
        step(1, 1, 4'h0, 0, 16'h0);
        check("nt_flush", flush, 1'b0);    check("nt_pc", ir_pc, 16'h0012);

        // Backward JNE -2 at 0x0020 with Z=0
        rom[16'h0020 >> 1] = 16'h23FE;
        step(1, 0, 4'h0, 1, 16'h0020);
        step(1, 0, 4'h0, 0, 16'h0);
        step(1, 1, 4'h0, 0, 16'h0);
        check("bj_flush", flush, 1'b1);
        step(1, 0, 4'h0, 0, 16'h0);
        check("bj_pc", ir_pc, 16'h001E);

        // Jump look-alike popped as an extension word
        rom[16'h0030 >> 1] = 16'h3C05;
        step(1, 0, 4'h0, 1, 16'h0030);
        step(1, 0, 4'h0, 0, 16'h0);
        step(1, 0, 4'h0, 0, 16'h0);
        check("ext_flush", flush, 1'b0);   check("ext_pc", ir_pc, 16'h0032);

        // Back-pressure from an empty queue
        step(1, 0, 4'h0, 1, 16'h0040);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'h0, 0, 16'h0);
            if (i >= 1) begin
                check("bp_romrd", rom_rd, 1'b0);
                check("bp_pc", ir_pc, 16'h0040);
                check("bp_word", ir_word, rom[16'h0040 >> 1]);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 4'h0, 0, 16'h0);
            check("bp_rel_pc", ir_pc, 16'(16'h0040 + 2 * i));
        end

        // pc_load beats a simultaneous taken jump
        rom[16'h0050 >> 1] = 16'h3C03;
        step(1, 0, 4'h0, 1, 16'h0050);
        step(1, 0, 4'h0, 0, 16'h0);
        step(1, 1, 4'h0, 1, 16'hF001);
        check("cf_addr", rom_addr, 16'hF000);
        step(1, 0, 4'h0, 0, 16'h0);
        check("cf_pc", ir_pc, 16'hF000);

        // Sequential wrap at the top of memory
        rom[16'hFFFE >> 1] = 16'h4000;
        rom[0]             = 16'h4034;
        step(1, 0, 4'h0, 1, 16'hFFFE);
        step(1, 0, 4'h0, 0, 16'h0);
        check("wr_pc_hi", ir_pc, 16'hFFFE);
        step(1, 0, 4'h0, 0, 16'h0);
        check("wr_pc_lo", ir_pc, 16'h0000);

        // Reset asserted mid-redirect acts immediately
        step(1, 0, 4'h0, 1, 16'h0100);
        #2 rst = 1'b1;
        #1;
        check("mr_valid",   ir_valid, 1'b0);
        check("mr_romaddr", rom_addr, RESET_PC);
        check("mr_flush",   flush, 1'b0);
        check("mr_romrd",   rom_rd, 1'b0);
        check("mr_pc",      ir_pc, RESET_PC);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 31) == 0), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
